pl_muldiv_unit: RTL and testbench

- Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core.
- Adds MULT/MULTU/DIV/DIVU and MTHI/MTLO, backed by architectural HI/LO registers.
- Multiply is a fixed-latency pipelined path; divide is an iterative restoring divider.
- `busy` drives the core's stall logic; `flush` squashes an in-flight op when the EX stage is flushed by a branch, jump or interrupt.

---
 rtl/pl_muldiv_unit_if.sv | 26 ++
 rtl/pl_muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_pl_muldiv_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The core drives the request side; the unit drives status and HI/LO.
interface pl_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, flush, A, B,
    input  busy, done, div_by_zero, HI, LO
  );

  modport slave (
    input  start, op, flush, A, B,
    output busy, done, div_by_zero, HI, LO
  );
endinterface

// File: rtl/pl_muldiv_unit.sv
// EX-stage multiply/divide unit: fixed-latency multiply, restoring divide, HI/LO registers.
// Results land in HI/LO with a one-cycle done pulse; flush squashes any in-flight op.
module pl_muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input logic             CLK,
  input logic             Reset_n,
  pl_muldiv_unit_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  localparam int unsigned CntMax = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDivSetup, StDivIter, StDivFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_signed_q, is_signed_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b, div_zero;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, mul_full, mul_res;
  logic [WIDTH:0]     shifted, trial;
  logic               q_bit;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;

  assign sign_a   = is_signed_q & opa_q[WIDTH-1];
  assign sign_b   = is_signed_q & opb_q[WIDTH-1];
  assign div_zero = (opb_q == '0);

  // Sign-extending to 2*WIDTH makes one unsigned multiplier serve MULT and MULTU.
  assign mul_a_ext = {{WIDTH{sign_a}}, opa_q};
  assign mul_b_ext = {{WIDTH{sign_b}}, opb_q};
  assign mul_full  = mul_a_ext * mul_b_ext;
  assign mul_res   = (MUL_LATENCY == 1) ? mul_full : prod_q;

  // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign q_bit   = shifted[WIDTH] | ~trial[WIDTH];

  assign quot_fixed = (sign_a ^ sign_b) ? -quot_q : quot_q;
  assign rem_fixed  = sign_a ? -rem_q : rem_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    is_signed_d = is_signed_q;
    prod_d      = prod_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          unique case (bus.op)
            OpMult, OpMultu: begin
              state_d     = StMul;
              cnt_d       = '0;
              opa_d       = bus.A;
              opb_d       = bus.B;
              is_signed_d = (bus.op == OpMult);
            end
            OpDiv, OpDivu: begin
              state_d     = StDivSetup;
              cnt_d       = '0;
              opa_d       = bus.A;
              opb_d       = bus.B;
              is_signed_d = (bus.op == OpDiv);
            end
            OpMthi:  hi_d = bus.A;
            OpMtlo:  lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StMul: begin
        prod_d = mul_full;
        if (cnt_q == MulLast) begin
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = StIdle;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDivSetup: begin
        quot_d  = sign_a ? -opa_q : opa_q;
        dvsr_d  = sign_b ? -opb_q : opb_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = StDivIter;
      end
      StDivIter: begin
        rem_d  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], q_bit};
        if (cnt_q == DivLast) begin
          state_d = StDivFix;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDivFix: begin
        if (div_zero) begin
          lo_d = '1;
          hi_d = opa_q;
        end else begin
          lo_d = quot_fixed;
          hi_d = rem_fixed;
        end
        done_d  = 1'b1;
        dbz_d   = div_zero;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A flush beats a result on the same edge: nothing reaches HI/LO.
    if (bus.flush && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      is_signed_q <= 1'b0;
      prod_q      <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      is_signed_q <= is_signed_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;

endmodule

// File: tb/tb_pl_muldiv_unit.sv
// Directed bench for pl_muldiv_unit: multiply, divide, MTHI/MTLO, flush and reset scenarios.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_pl_muldiv_unit;
  localparam int unsigned W = 32;

  logic CLK;
  logic Reset_n;
  int   n_vec;
  int   n_err;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } div_vec_t;

  pl_muldiv_unit_if #(.WIDTH(W)) bus ();

  pl_muldiv_unit #(
    .WIDTH      (W),
    .MUL_LATENCY(2)
  ) dut (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    bus.start = s;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic test_reset();
    Reset_n   = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    #2 Reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
        bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      n_err++;
      $display("FAIL reset_async: got busy=%b done=%b dbz=%b HI=%h LO=%h, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO);
    end
    tick();
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      n_err++;
      $display("FAIL reset_held: got busy=%b done=%b HI=%h LO=%h, want all 0",
               bus.busy, bus.done, bus.HI, bus.LO);
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    drive(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5);
    tick();  // edge 0
    drive(1'b0, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mult_e0: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
    end
    tick();  // edge 1
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mult_e1: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
    end
    tick();  // edge 2
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.HI !== 32'hFFFF_FFFF ||
        bus.LO !== 32'hFFFF_FFF1) begin
      n_err++;
      $display("FAIL mult_result: got busy=%b done=%b HI=%h LO=%h, want 0 1 ffffffff fffffff1",
               bus.busy, bus.done, bus.HI, bus.LO);
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFF1) begin
      n_err++;
      $display("FAIL mult_after: got done=%b HI=%h LO=%h, want 0 ffffffff fffffff1",
               bus.done, bus.HI, bus.LO);
    end
  endtask

  task automatic test_multu_mt();
    drive(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b1 || bus.HI !== 32'hFFFF_FFFE || bus.LO !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL multu_result: got done=%b HI=%h LO=%h, want 1 fffffffe 00000001",
               bus.done, bus.HI, bus.LO);
    end
    drive(1'b1, 3'd5, 32'h0000_1234, 32'h0);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    n_vec++;
    if (bus.LO !== 32'h0000_1234 || bus.HI !== 32'hFFFF_FFFE || bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo: got LO=%h HI=%h done=%b busy=%b, want 00001234 fffffffe 0 0",
               bus.LO, bus.HI, bus.done, bus.busy);
    end
    drive(1'b1, 3'd4, 32'hCAFE_0001, 32'h0);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    n_vec++;
    if (bus.HI !== 32'hCAFE_0001 || bus.LO !== 32'h0000_1234 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mthi: got HI=%h LO=%h done=%b busy=%b, want cafe0001 00001234 0 0",
               bus.HI, bus.LO, bus.done, bus.busy);
    end
    drive(1'b1, 3'd6, 32'hBEEF_BEEF, 32'h1);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    tick();
    n_vec++;
    if (bus.HI !== 32'hCAFE_0001 || bus.LO !== 32'h0000_1234 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL noop_op6: got HI=%h LO=%h done=%b busy=%b, want cafe0001 00001234 0 0",
               bus.HI, bus.LO, bus.done, bus.busy);
    end
  endtask

  task automatic test_div();
    div_vec_t v [6];
    logic     bad;
    v[0] = '{op: 3'd2, a: 32'hFFFF_FFF9, b: 32'd2, lo: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, dbz: 1'b0};
    v[1] = '{op: 3'd3, a: 32'd100, b: 32'd7, lo: 32'd14, hi: 32'd2, dbz: 1'b0};
    v[2] = '{op: 3'd3, a: 32'h64, b: 32'h0, lo: 32'hFFFF_FFFF, hi: 32'h64, dbz: 1'b1};
    v[3] = '{op: 3'd2, a: 32'h8000_0000, b: 32'hFFFF_FFFF, lo: 32'h8000_0000, hi: 32'h0,
             dbz: 1'b0};
    v[4] = '{op: 3'd2, a: 32'd7, b: 32'hFFFF_FFFE, lo: 32'hFFFF_FFFD, hi: 32'd1, dbz: 1'b0};
    v[5] = '{op: 3'd2, a: 32'hFFFF_FFFB, b: 32'h0, lo: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFB,
             dbz: 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, v[i].op, v[i].a, v[i].b);
      tick();  // edge 0
      drive(1'b0, 3'd7, 32'h0, 32'h0);
      bad = 1'b0;
      for (int k = 1; k <= 34; k++) begin
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
        tick();
      end
      n_vec++;
      if (bad !== 1'b0) begin
        n_err++;
        $display("FAIL div%0d_latency: got early done or busy drop before edge 34, want none", i);
      end
      n_vec++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.div_by_zero !== v[i].dbz ||
          bus.LO !== v[i].lo || bus.HI !== v[i].hi) begin
        n_err++;
        $display("FAIL div%0d_result: got done=%b busy=%b dbz=%b LO=%h HI=%h, want 1 0 %b %h %h",
                 i, bus.done, bus.busy, bus.div_by_zero, bus.LO, bus.HI, v[i].dbz, v[i].lo,
                 v[i].hi);
      end
      tick();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL div%0d_after: got done=%b busy=%b, want 0 0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_flush();
    logic bad;
    drive(1'b1, 3'd4, 32'hAAAA_0000, 32'h0);
    tick();
    drive(1'b1, 3'd5, 32'h0000_5555, 32'h0);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    // DIV in flight; starts during edges 3..9 must be ignored.
    drive(1'b1, 3'd2, 32'd50, 32'd3);
    tick();  // edge 0
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    tick();
    tick();  // edge 2
    drive(1'b1, 3'd4, 32'hDEAD_0000, 32'h0);
    for (int k = 3; k <= 9; k++) tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    tick();  // edge 10
    n_vec++;
    if (bus.busy !== 1'b1 || bus.HI !== 32'hAAAA_0000 || bus.LO !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL busy_start_ignored: got busy=%b HI=%h LO=%h, want 1 aaaa0000 00005555",
               bus.busy, bus.HI, bus.LO);
    end
    bus.flush = 1'b1;
    tick();  // edge 11
    bus.flush = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== 32'hAAAA_0000 ||
        bus.LO !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL flush_mid_div: got busy=%b done=%b HI=%h LO=%h, want 0 0 aaaa0000 00005555",
               bus.busy, bus.done, bus.HI, bus.LO);
    end
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.HI !== 32'hAAAA_0000 ||
          bus.LO !== 32'h0000_5555) bad = 1'b1;
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_late_done: got activity after flush, want none");
    end
    // Flush in IDLE blocks acceptance.
    bus.flush = 1'b1;
    drive(1'b1, 3'd5, 32'h0000_0077, 32'h0);
    tick();
    drive(1'b1, 3'd2, 32'd9, 32'd2);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.LO !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL flush_idle_block: got busy=%b LO=%h, want 0 00005555", bus.busy, bus.LO);
    end
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_later: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    // Flush on the result edge wins over the result.
    drive(1'b1, 3'd2, 32'd50, 32'd3);
    tick();  // edge 0
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    for (int k = 1; k <= 33; k++) tick();
    bus.flush = 1'b1;
    tick();  // edge 34
    bus.flush = 1'b0;
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.HI !== 32'hAAAA_0000 ||
        bus.LO !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL flush_result_edge: got done=%b busy=%b HI=%h LO=%h, want 0 0 aaaa0000 00005555",
               bus.done, bus.busy, bus.HI, bus.LO);
    end
    tick();
    n_vec++;
    if (bus.done !== 1'b0 || bus.LO !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL flush_result_after: got done=%b LO=%h, want 0 00005555", bus.done, bus.LO);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd0, 32'd2, 32'd3);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b1 || bus.LO !== 32'd6 || bus.HI !== 32'd0) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b HI=%h LO=%h, want 1 0 6", bus.done, bus.HI, bus.LO);
    end
    drive(1'b1, 3'd1, 32'd4, 32'd5);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b1 || bus.LO !== 32'd20 || bus.HI !== 32'd0) begin
      n_err++;
      $display("FAIL b2b_second: got done=%b HI=%h LO=%h, want 1 0 14", bus.done, bus.HI, bus.LO);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd4, 32'h0000_0099, 32'h0);
    tick();
    drive(1'b1, 3'd2, 32'd1000, 32'd3);
    tick();  // edge 0
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    for (int k = 1; k <= 20; k++) tick();
    #2 Reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_div: got HI=%h LO=%h busy=%b done=%b, want 0 0 0 0",
               bus.HI, bus.LO, bus.busy, bus.done);
    end
    #2 Reset_n = 1'b1;
    tick();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    drive(1'b1, 3'd0, 32'd6, 32'd7);
    tick();
    drive(1'b0, 3'd7, 32'h0, 32'h0);
    tick();
    tick();
    n_vec++;
    if (bus.done !== 1'b1 || bus.LO !== 32'd42 || bus.HI !== 32'd0) begin
      n_err++;
      $display("FAIL reset_then_mult: got done=%b HI=%h LO=%h, want 1 0 2a",
               bus.done, bus.HI, bus.LO);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_multu_mt();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
